ct_f_spsram_init_ctrl: RTL
==========================

# ct_f_spsram_init_ctrl

Requester-side controller for the `ct_f_spsram_*` single-port SRAM macros. It clears the whole array after reset. It then converts a valid/ready request stream (read or masked write) into the SRAM's active-low CEN/GWEN/WEN strobes, and returns read data on a valid/ready response channel with one-entry buffering. It sits between a cache/BHT/TLB pipeline and the SRAM wrapper, and is the initiator end of the macro's port.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, SRAM address width; depth = 2^ADDR_WIDTH.
- `DATA_WIDTH`, 23, SRAM word width.
- `INIT_EN`, 1, 1 = clear array after reset; 0 = skip INIT.
- `INIT_VALUE`, 0, word written to every entry during INIT.

Ports:
- `CLK`  in  1  clock; all logic on posedge.
- `RST`  in  1  reset, synchronous, active-high.
- `req_vld`  in  1  request valid.
- `req_rdy`  out  1  request ready.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  request address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `req_wmask`  in  DATA_WIDTH  per-bit write enable, active-high.
- `rsp_vld`  out  1  read response valid.
- `rsp_rdy`  in  1  read response ready.
- `rsp_rdata`  out  DATA_WIDTH  read data.
- `init_done`  out  1  array cleared, requests accepted.
- `sram_a`  out  ADDR_WIDTH  to SRAM `A`.
- `sram_cen`  out  1  to SRAM `CEN`, active-low.
- `sram_gwen`  out  1  to SRAM `GWEN`, active-low.
- `sram_wen`  out  DATA_WIDTH  to SRAM `WEN`, active-low.
- `sram_d`  out  DATA_WIDTH  to SRAM `D`.
- `sram_q`  in  DATA_WIDTH  from SRAM `Q`.

## Operation
- FSM states: INIT and RUN.
  - `RST` forces INIT with `init_cnt`=0.
  - If `INIT_EN`=0, `RST` forces RUN instead.
- INIT:
  - Each cycle drives `sram_cen`=0, `sram_gwen`=0, `sram_wen`=all-0, `sram_a`=`init_cnt`, `sram_d`=`INIT_VALUE`.
  - `init_cnt` increments each cycle. When `init_cnt`==2^ADDR_WIDTH−1, that write completes and the FSM moves to RUN.
  - `req_rdy`=0 throughout.
- RUN:
  - `init_done`=1.
  - `fire` = `req_vld` && `req_rdy`. `capture` = `rd_pend` && (!`rsp_vld` || `rsp_rdy`).
  - `req_rdy` = !`rd_pend` || !`rsp_vld` || `rsp_rdy`.
  - SRAM strobes are combinational from the request:
    - `sram_cen` = !`fire`
    - `sram_gwen` = !(`fire` && `req_wr`)
    - `sram_wen` = `fire` && `req_wr` ? ~`req_wmask` : all-1
    - `sram_a` = `req_addr`
    - `sram_d` = `req_wdata`
  - Idle cycles (no `fire`) drive `sram_cen`=1, `sram_gwen`=1, `sram_wen`=all-1, with `sram_a`/`sram_d` following the request inputs. The SRAM holds its latched address, so `sram_q` stays stable.
  - Writes produce no response.
  - Read `fire` sets `rd_pend` at the next edge.
  - On `capture`: `rsp_rdata` <= `sram_q`, `rsp_vld` <= 1, and `rd_pend` clears unless a new read fires in the same cycle.
  - `rsp_vld` clears on `rsp_vld` && `rsp_rdy` when no capture occurs that cycle.
- Response stall: while `rd_pend` && `rsp_vld` && !`rsp_rdy`, `req_rdy`=0 and no SRAM access is issued. `sram_q` remains valid for the pending read.
- Write and read to the same address in consecutive cycles: the read returns the written data. A write issued in the cycle a pending read is captured does not affect the captured data.

## Timing
- Reset values:
  - `req_rdy`=0, `rsp_vld`=0, `rsp_rdata`=0, `init_done`=0.
  - `sram_cen`=1, `sram_gwen`=1, `sram_wen`=all-1, `sram_a`=0, `sram_d`=0.
  - Internal: `rd_pend`=0, `init_cnt`=0.
- INIT takes exactly 2^ADDR_WIDTH cycles, counted from the first cycle with `RST`=0. `init_done` rises in the following cycle (cycle 257 for the defaults).
- Read latency: request fires in cycle c, SRAM `Q` is valid in c+1, `rsp_vld`=1 in c+2.
- Throughput is one read per cycle while `rsp_rdy`=1.
- A write fires in cycle c and is committed at the end of c.
- `RST` during INIT or RUN: the next cycle shows reset values, a pending or buffered response is dropped, and INIT restarts from address 0.

## Test plan
- Reset release with defaults:
  - Exactly 256 write cycles with `sram_a` 0..255 and `sram_d`=0.
  - `init_done`=1 from cycle 257.
  - A read of any address then returns 0.
- Write `req_addr`=0x3C, data 0x5A5A5, mask all-1, then read 0x3C:
  - `rsp_vld` rises 2 cycles after the read fires.
  - `rsp_rdata`=0x5A5A5.
- Masked write with `req_wmask`=0x0000FF and data 0x7FFFFF over existing 0x123400 -> read returns 0x1234FF.
- Four back-to-back reads (addresses 1..4) with `rsp_rdy`=1 -> four consecutive `rsp_vld` cycles returning data in order, no bubbles.
- Response stall:
  - With `rsp_rdy`=0, issue reads A then B.
  - `req_rdy` drops, `sram_cen` stays 1, and `rsp_rdata` holds A's data.
  - Raise `rsp_rdy`: A then B are delivered with correct data.
- Assert `RST` for 1 cycle mid-RUN with a read pending -> `rsp_vld`=0 and `init_done`=0 next cycle, INIT restarts at address 0, and no stale response appears.

Source files
------------

// File: rtl/ct_f_spsram_init_ctrl.sv
// ct_f_spsram_init_ctrl
// Requester-side controller for a single-port SRAM macro. After reset it
// writes INIT_VALUE to every entry, then turns a valid/ready request stream
// into active-low CEN/GWEN/WEN strobes and returns read data on a
// valid/ready response channel with one-entry buffering.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both 1. A producer holds valid and its payload
// stable until the transfer; ready may depend combinationally on the
// consumer's state. req_rdy is combinational from rd_pend/rsp_vld/rsp_rdy;
// rsp_vld and rsp_rdata are registered.
module ct_f_spsram_init_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           DATA_WIDTH = 23,
    parameter bit                    INIT_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // With clearing disabled the controller comes out of reset ready to run.
    localparam state_t                  RST_STATE = INIT_EN ? ST_INIT : ST_RUN;
    localparam logic [ADDR_WIDTH-1:0]   LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0]   CNT_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q,  init_cnt_d;
    logic                  rd_pend_q,   rd_pend_d;
    logic                  rsp_vld_q,   rsp_vld_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    // fire: a request transfers this cycle; capture: the SRAM Q of the
    // outstanding read moves into the response buffer at this edge.
    logic fire;
    logic capture;

    // Next-state and output decode. While RST is high every output shows its
    // reset value so the macro sees no access during the reset cycle itself.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        rd_pend_d   = rd_pend_q;
        rsp_vld_d   = rsp_vld_q;
        rsp_rdata_d = rsp_rdata_q;
        fire        = 1'b0;
        capture     = 1'b0;
        req_rdy     = 1'b0;
        init_done   = 1'b0;
        sram_cen    = 1'b1;
        sram_gwen   = 1'b1;
        sram_wen    = '1;
        sram_a      = '0;
        sram_d      = '0;

        if (!RST) begin
            case (state_q)
                ST_INIT: begin
                    // Full-word write of INIT_VALUE to one entry per cycle.
                    sram_cen   = 1'b0;
                    sram_gwen  = 1'b0;
                    sram_wen   = '0;
                    sram_a     = init_cnt_q;
                    sram_d     = INIT_VALUE;
                    init_cnt_d = init_cnt_q + CNT_ONE;
                    if (init_cnt_q == LAST_ADDR) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    init_done = 1'b1;
                    // A new access is only allowed when the outstanding read
                    // (if any) can be captured this cycle; otherwise the SRAM
                    // must keep Q for it.
                    req_rdy   = !rd_pend_q || !rsp_vld_q || rsp_rdy;
                    fire      = req_vld && req_rdy;
                    capture   = rd_pend_q && (!rsp_vld_q || rsp_rdy);
                    sram_cen  = !fire;
                    sram_gwen = !(fire && req_wr);
                    sram_wen  = (fire && req_wr) ? ~req_wmask : '1;
                    sram_a    = req_addr;
                    sram_d    = req_wdata;

                    if (fire && !req_wr) begin
                        rd_pend_d = 1'b1;
                    end else if (capture) begin
                        rd_pend_d = 1'b0;
                    end

                    if (capture) begin
                        rsp_vld_d   = 1'b1;
                        rsp_rdata_d = sram_q;
                    end else if (rsp_vld_q && rsp_rdy) begin
                        rsp_vld_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = RST_STATE;
                end
            endcase
        end
    end

    // State registers with synchronous reset; a reset drops any pending or
    // buffered read response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RST_STATE;
            init_cnt_q  <= '0;
            rd_pend_q   <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_vld   = rsp_vld_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
